// File: rtl/unit_pkg.sv
// Shared types for the unit MAC: state encoding and Mode operation codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_MAC = 2'b00;  // Y += A*B
    localparam logic [1:0] MODE_ADD = 2'b01;  // Y += A+B
    localparam logic [1:0] MODE_SUB = 2'b10;  // Y -= A+B
    localparam logic [1:0] MODE_NOP = 2'b11;  // step counted, Y unchanged

endpackage

// File: rtl/unit_alu.sv
// Combinational next-accumulator datapath: term select, add/sub, wrap or clamp, range detect.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is consumed only on step edges by the owner.
// Ports: y (current accumulator), a/b (operands), mode (op code) -> y_nxt (next value), ovf (unclamped
//        result left [0, 2^OUT_W-1] on this op).
module unit_alu
    import unit_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 8,
    parameter int SAT   = 0
) (
    input  logic [OUT_W-1:0] y,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] y_nxt,
    output logic             ovf
);

    logic [2*IN_W-1:0] prod;
    logic [IN_W:0]     sum_ab;
    logic [OUT_W+1:0]  acc_x;
    logic [OUT_W+1:0]  term_x;
    logic [OUT_W+1:0]  res;

    assign prod   = {{IN_W{1'b0}}, a} * {{IN_W{1'b0}}, b};
    assign sum_ab = {1'b0, a} + {1'b0, b};

    // Two guard bits: bit OUT_W catches carry out of an add, bit OUT_W+1
    // catches the borrow of a subtract that went below zero.
    assign acc_x  = {2'b00, y};

    always_comb begin
        term_x = (OUT_W+2)'(sum_ab);
        if (mode == MODE_MAC) begin
            term_x = (OUT_W+2)'(prod);
        end

        res = acc_x;
        case (mode)
            MODE_MAC, MODE_ADD: res = acc_x + term_x;
            MODE_SUB:           res = acc_x - term_x;
            default:            res = acc_x;
        endcase

        ovf   = |res[OUT_W+1:OUT_W];
        y_nxt = res[OUT_W-1:0];
        if ((SAT != 0) && ovf) begin
            y_nxt = (mode == MODE_SUB) ? '0 : '1;
        end
    end

endmodule

// File: rtl/unit_mac.sv
// Run-controlled multiply/add/subtract accumulator that stops after STEPS steps until cleared.
// Latency: step result on Yout/nYout/Count the edge after it is applied; Done the edge entering DONE.
// Backpressure: Run=0 freezes the run (HOLD); DONE ignores Run until Clear or reset.
// Ports: clk, nReset (sync active-low), A/B operands, Mode op, Run, Clear -> Yout, nYout, Count,
//        Ovf (sticky range error), Done.
module unit_mac
    import unit_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 8,
    parameter int STEPS = 15,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    input  logic [1:0]       Mode,
    input  logic             Run,
    input  logic             Clear,
    output logic [OUT_W-1:0] Yout,
    output logic [OUT_W-1:0] nYout,
    output logic [15:0]      Count,
    output logic             Ovf,
    output logic             Done
);

    state_t           state, state_nxt;
    logic [OUT_W-1:0] alu_y;
    logic             alu_ovf;
    logic             step;
    logic             last_step;

    unit_alu #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SAT   (SAT)
    ) u_alu (
        .y     (Yout),
        .a     (A),
        .b     (B),
        .mode  (Mode),
        .y_nxt (alu_y),
        .ovf   (alu_ovf)
    );

    // A, B and Mode only matter on step edges; anywhere else the ALU output is ignored.
    assign step      = (state != DONE) && Run && !Clear;
    assign last_step = (Count + 16'd1) == 16'(STEPS);

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state <= IDLE;
            Yout  <= '0;
            Count <= '0;
            Ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (Clear) begin
                Yout  <= '0;
                Count <= '0;
                Ovf   <= 1'b0;
            end else if (step) begin
                Yout  <= alu_y;
                Count <= Count + 16'd1;
                Ovf   <= Ovf | alu_ovf;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (Clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) state_nxt = last_step ? DONE : RUN;
                end
                RUN, HOLD: begin
                    if (Run) state_nxt = last_step ? DONE : RUN;
                    else     state_nxt = HOLD;
                end
                default: state_nxt = DONE;
            endcase
        end
    end

    assign nYout = ~Yout;
    assign Done  = (state == DONE);

endmodule

// File: tb/tb_unit_mac.sv
module tb_unit_mac;

    logic       clk = 1'b0;
    logic       nReset, Run, Clear;
    logic [1:0] A, B, Mode;

    logic [7:0]  yo  [3];
    logic [7:0]  nyo [3];
    logic [15:0] cnt [3];
    logic        ovf [3];
    logic        dn  [3];

    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: STEPS=31 wrap. Instance 2: STEPS=31 clamp.
    unit_mac u0 (.clk(clk), .nReset(nReset), .A(A), .B(B), .Mode(Mode), .Run(Run), .Clear(Clear),
                 .Yout(yo[0]), .nYout(nyo[0]), .Count(cnt[0]), .Ovf(ovf[0]), .Done(dn[0]));
    unit_mac #(.STEPS(31), .SAT(0)) u1 (.clk(clk), .nReset(nReset), .A(A), .B(B), .Mode(Mode),
                 .Run(Run), .Clear(Clear), .Yout(yo[1]), .nYout(nyo[1]), .Count(cnt[1]),
                 .Ovf(ovf[1]), .Done(dn[1]));
    unit_mac #(.STEPS(31), .SAT(1)) u2 (.clk(clk), .nReset(nReset), .A(A), .B(B), .Mode(Mode),
                 .Run(Run), .Clear(Clear), .Yout(yo[2]), .nYout(nyo[2]), .Count(cnt[2]),
                 .Ovf(ovf[2]), .Done(dn[2]));

    typedef struct packed {
        logic [1:0]  idx;
        logic [7:0]  y;
        logic [7:0]  ny;
        logic [15:0] cnt;
        logic        ovf;
        logic        done;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int errors  = 0;

    int steps_p [3] = '{15, 31, 31};
    bit sat_p   [3] = '{0, 0, 1};
    int m_y     [3] = '{0, 0, 0};
    int m_cnt   [3] = '{0, 0, 0};
    bit m_ovf   [3] = '{0, 0, 0};
    bit m_done  [3] = '{0, 0, 0};

    task automatic cmp(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s u%0d: observed %0d expected %0d", tag, inst, obs, exp_v);
        end
    endtask

    // Apply one edge: drive inputs, advance the reference model, queue its
    // expectations, clock, then pop and compare against all three instances.
    task automatic tick(input logic rn, input logic cl, input logic ru,
                        input logic [1:0] md, input logic [1:0] a_i, input logic [1:0] b_i);
        int r;
        exp_t e;
        nReset = rn; Clear = cl; Run = ru; Mode = md; A = a_i; B = b_i;
        for (int i = 0; i < 3; i++) begin
            if (!rn || cl) begin
                m_y[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
            end else if (ru && !m_done[i]) begin
                case (md)
                    2'b00:   r = m_y[i] + int'(a_i) * int'(b_i);
                    2'b01:   r = m_y[i] + int'(a_i) + int'(b_i);
                    2'b10:   r = m_y[i] - (int'(a_i) + int'(b_i));
                    default: r = m_y[i];
                endcase
                if (r < 0 || r > 255) m_ovf[i] = 1;
                if (sat_p[i]) m_y[i] = (r < 0) ? 0 : (r > 255) ? 255 : r;
                else          m_y[i] = r & 255;
                m_cnt[i]++;
                if (m_cnt[i] == steps_p[i]) m_done[i] = 1;
            end
            e.idx  = 2'(i);
            e.y    = 8'(m_y[i]);
            e.ny   = 8'(255 - m_y[i]);
            e.cnt  = 16'(m_cnt[i]);
            e.ovf  = m_ovf[i];
            e.done = m_done[i];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("yout",  int'(e.idx), 16'(yo[e.idx]),  16'(e.y));
            cmp("nyout", int'(e.idx), 16'(nyo[e.idx]), 16'(e.ny));
            cmp("count", int'(e.idx), cnt[e.idx],      e.cnt);
            cmp("ovf",   int'(e.idx), 16'(ovf[e.idx]), 16'(e.ovf));
            cmp("done",  int'(e.idx), 16'(dn[e.idx]),  16'(e.done));
        end
    endtask

    initial begin
        nReset = 1'b0; Clear = 1'b0; Run = 1'b0; Mode = 2'b00; A = '0; B = '0;
        #1;

        // Reset held two edges while Run is asserted with nonzero operands.
        tick(0, 0, 1, 2'b00, 2'd3, 2'd3);
        tick(0, 0, 1, 2'b00, 2'd3, 2'd3);

        // ADD 1+1 for 20 edges: u0 reaches DONE at edge 15 and freezes at 30.
        for (int k = 0; k < 20; k++) tick(1, 0, 1, 2'b01, 2'd1, 2'd1);

        // DONE ignores Run and Mode changes.
        tick(1, 0, 1, 2'b00, 2'd3, 2'd3);

        // MAC 3*3: 5 steps, 10 hold cycles with operands changing, 5 more steps.
        tick(1, 1, 1, 2'b00, 2'd3, 2'd3);
        for (int k = 0; k < 5; k++)  tick(1, 0, 1, 2'b00, 2'd3, 2'd3);
        for (int k = 0; k < 10; k++) tick(1, 0, 0, 2'b10, 2'd2, 2'd1);
        for (int k = 0; k < 5; k++)  tick(1, 0, 1, 2'b00, 2'd3, 2'd3);

        // MAC 3*3 for 29 steps from zero: wraps/clamps on step 29 in u1/u2.
        tick(1, 1, 0, 2'b00, 2'd0, 2'd0);
        for (int k = 0; k < 29; k++) tick(1, 0, 1, 2'b00, 2'd3, 2'd3);
        // Ovf stays set after further in-range steps.
        tick(1, 0, 1, 2'b11, 2'd3, 2'd3);

        // SUB from zero: underflow in one step.
        tick(1, 1, 0, 2'b00, 2'd0, 2'd0);
        tick(1, 0, 1, 2'b10, 2'd1, 2'd0);

        // Mixed modes with mid-run operand changes, including NOP steps.
        tick(1, 1, 0, 2'b00, 2'd0, 2'd0);
        tick(1, 0, 1, 2'b00, 2'd2, 2'd3);
        tick(1, 0, 1, 2'b11, 2'd3, 2'd3);
        tick(1, 0, 1, 2'b01, 2'd3, 2'd2);
        tick(1, 0, 1, 2'b10, 2'd1, 2'd2);
        tick(1, 0, 0, 2'b00, 2'd3, 2'd3);
        tick(1, 0, 1, 2'b11, 2'd0, 2'd0);

        // Reach Yout=20 in RUN, then Clear together with Run.
        tick(1, 1, 0, 2'b00, 2'd0, 2'd0);
        tick(1, 0, 1, 2'b01, 2'd3, 2'd2);
        tick(1, 0, 1, 2'b01, 2'd3, 2'd2);
        tick(1, 0, 1, 2'b01, 2'd3, 2'd2);
        tick(1, 0, 1, 2'b01, 2'd3, 2'd2);
        tick(1, 1, 1, 2'b01, 2'd3, 2'd2);
        tick(1, 0, 1, 2'b01, 2'd3, 2'd2);

        // Reset mid-run with Clear low and Run high, then resume from zero.
        tick(1, 0, 1, 2'b00, 2'd3, 2'd3);
        tick(0, 0, 1, 2'b00, 2'd3, 2'd3);
        tick(1, 0, 1, 2'b00, 2'd1, 2'd1);

        // Reset while u0 sits in DONE, with Clear also asserted.
        for (int k = 0; k < 16; k++) tick(1, 0, 1, 2'b01, 2'd0, 2'd1);
        tick(0, 1, 1, 2'b01, 2'd0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/unit_mac.md
UNIT_MAC -- requirements
Module: unit_mac

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; ports clk and nReset.
REQ-002 Parameter IN_W, default 2: width of operands A and B.
REQ-003 Parameter OUT_W, default 8: accumulator width, must be >= 2*IN_W+1.
REQ-004 Parameter STEPS, default 15: accumulation steps per run, 1..2^16-1.
REQ-005 Parameter SAT, default 0: 0 = wrap on overflow, 1 = clamp on overflow.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 nReset  in  1  synchronous active-low reset.
REQ-008 A  in  IN_W  unsigned operand.
REQ-009 B  in  IN_W  unsigned operand.
REQ-010 Mode  in  2  operation: 00 MAC (Y+=A*B), 01 ADD (Y+=A+B), 10 SUB (Y-=A+B), 11 NOP.
REQ-011 Run  in  1  1 = accumulate on this edge, 0 = hold.
REQ-012 Clear  in  1  synchronous clear of accumulator, counter and flags.
REQ-013 Yout  out  OUT_W  registered accumulator value.
REQ-014 nYout  out  OUT_W  bitwise complement of Yout, combinational.
REQ-015 Count  out  16  registered number of steps taken in the current run.
REQ-016 Ovf  out  1  sticky overflow/underflow flag.
REQ-017 Done  out  1  high while in state DONE.

Function
REQ-018 States SHALL be IDLE, RUN, HOLD, DONE.
REQ-019 Step: an edge where state is IDLE/RUN/HOLD, Run=1, Clear=0, nReset=1; Yout updates per Mode and Count increments on that edge.
REQ-020 Mode 11 SHALL count as a step but leave Yout unchanged.
REQ-021 Arithmetic SHALL be unsigned; A*B and A+B zero-extended to OUT_W+1 bits before the operation.
REQ-022 SAT=0: result truncated to OUT_W bits (wrap); SAT=1: result clamps to 2^OUT_W-1 on overflow, 0 on underflow.
REQ-023 Ovf SHALL set on the edge whose unclamped result leaves [0, 2^OUT_W-1] and stay set until Clear or reset.
REQ-024 Next state after a step: DONE if Count+1 == STEPS, else RUN.
REQ-025 RUN or HOLD with Run=0: next state HOLD; Yout, Count frozen.
REQ-026 IDLE with Run=0: stays IDLE.
REQ-027 DONE SHALL ignore Run and Mode; Yout, Count, Ovf frozen until Clear.
REQ-028 Clear=1 (any state): next edge Yout=0, Count=0, Ovf=0, state IDLE; Clear has priority over Run.
REQ-029 Mode, A, B SHALL be sampled only on step edges; mid-run changes apply at the next step.
REQ-030 Latency: step result visible on Yout/nYout/Count immediately after the step edge; Done asserts after the edge that enters DONE.

Reset
REQ-031 nReset=0 on an edge SHALL force Yout=0, Count=0, Ovf=0, state IDLE; nYout = all ones; Done=0.
REQ-032 nReset SHALL have priority over Clear and Run, including mid-run and in DONE.
REQ-033 No output SHALL change asynchronously with nReset.

Structure
REQ-034 Package unit_pkg SHALL hold the state enum and the Mode code constants.
REQ-035 Sub-module unit_alu (combinational: term generation, add/sub, wrap/clamp, overflow detect) SHALL be instantiated once; unit_mac holds state machine, counter and registers.

Verification (defaults unless stated)
REQ-036 nReset=0 two edges with Run=1, A=B=3 -> Yout=0, nYout=8'hFF, Count=0, Done=0, Ovf=0.
REQ-037 Mode=01, A=1, B=1, Run=1 for 20 edges -> Yout 2,4,..,30; Done=1 after edge 15; Yout=30, Count=15 thereafter.
REQ-038 Mode=00, A=3, B=3: 5 steps, Run=0 ten cycles, 5 steps -> Yout=45, Count=5 held during hold, then Yout=90, Count=10.
REQ-039 STEPS=31, Mode=00, A=B=3, 29 steps -> SAT=0: Yout=5, Ovf=1 from edge 29; SAT=1: Yout=255, Ovf=1.
REQ-040 From Yout=0, Mode=10, A=1, B=0, one step -> SAT=0: Yout=255, Ovf=1; SAT=1: Yout=0, Ovf=1.
REQ-041 In RUN at Yout=20: Clear=1 and Run=1 same edge -> Yout=0, Count=0, IDLE; separately nReset=0 with Clear=0 mid-run -> same reset values.
